// File: rtl/mux8_reg_pkg.sv
// Shared select-code type and per-input select constants for the mux8_reg slice.
package mux8_reg_pkg;

  typedef logic [2:0] sel_t;

  localparam sel_t SEL_I0 = 3'd0;
  localparam sel_t SEL_I1 = 3'd1;
  localparam sel_t SEL_I2 = 3'd2;
  localparam sel_t SEL_I3 = 3'd3;
  localparam sel_t SEL_I4 = 3'd4;
  localparam sel_t SEL_I5 = 3'd5;
  localparam sel_t SEL_I6 = 3'd6;
  localparam sel_t SEL_I7 = 3'd7;

endpackage

// File: rtl/mux8_comb.sv
// Pure combinational 8:1 selector; an unknown select yields an unknown result.
module mux8_comb
  import mux8_reg_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  input  logic [WIDTH-1:0] i3,
  input  logic [WIDTH-1:0] i4,
  input  logic [WIDTH-1:0] i5,
  input  logic [WIDTH-1:0] i6,
  input  logic [WIDTH-1:0] i7,
  input  logic [2:0]       s,
  output logic [WIDTH-1:0] y
);

  logic [WIDTH-1:0] in_arr [8];
  sel_t             sel;

  assign in_arr[SEL_I0] = i0;
  assign in_arr[SEL_I1] = i1;
  assign in_arr[SEL_I2] = i2;
  assign in_arr[SEL_I3] = i3;
  assign in_arr[SEL_I4] = i4;
  assign in_arr[SEL_I5] = i5;
  assign in_arr[SEL_I6] = i6;
  assign in_arr[SEL_I7] = i7;

  assign sel = s;
  // Array indexing rather than a case with a default keeps X on s visible.
  assign y   = in_arr[sel];

endmodule

// File: rtl/mux8_reg.sv
// Registered 8:1 multiplexer with enable, captured select code and valid flag.
module mux8_reg
  import mux8_reg_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  input  logic [WIDTH-1:0] i3,
  input  logic [WIDTH-1:0] i4,
  input  logic [WIDTH-1:0] i5,
  input  logic [WIDTH-1:0] i6,
  input  logic [WIDTH-1:0] i7,
  input  logic [2:0]       s,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_comb,
  output logic [2:0]       s_q,
  output logic             valid
);

  logic [WIDTH-1:0] sel_data;
  logic [WIDTH-1:0] y_q,     y_d;
  sel_t             sel_q,   sel_d;
  logic             valid_q, valid_d;

  mux8_comb #(
    .WIDTH (WIDTH)
  ) u_mux8_comb (
    .i0 (i0),
    .i1 (i1),
    .i2 (i2),
    .i3 (i3),
    .i4 (i4),
    .i5 (i5),
    .i6 (i6),
    .i7 (i7),
    .s  (s),
    .y  (sel_data)
  );

  always_comb begin
    y_d     = y_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    if (en) begin
      y_d     = sel_data;
      sel_d   = s;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q     <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      y_q     <= y_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
    end
  end

  assign y_comb = sel_data;
  assign y      = y_q;
  assign s_q    = sel_q;
  assign valid  = valid_q;

endmodule

// File: tb/tb_mux8_reg.sv
// Directed bench for mux8_reg: a WIDTH=1 and a WIDTH=8 instance share clock, reset, enable and select.
module tb_mux8_reg;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [2:0] s;
  logic       a1 [8];
  logic [7:0] d8 [8];

  logic       y1, yc1, v1;
  logic [2:0] sq1;
  logic [7:0] y8, yc8;
  logic       v8;
  logic [2:0] sq8;

  int unsigned n_total;
  int unsigned n_bad;

  mux8_reg #(.WIDTH(1)) u_dut1 (
    .clk (clk), .rst_n (rst_n), .en (en),
    .i0 (a1[0]), .i1 (a1[1]), .i2 (a1[2]), .i3 (a1[3]),
    .i4 (a1[4]), .i5 (a1[5]), .i6 (a1[6]), .i7 (a1[7]),
    .s (s), .y (y1), .y_comb (yc1), .s_q (sq1), .valid (v1)
  );

  mux8_reg #(.WIDTH(8)) u_dut8 (
    .clk (clk), .rst_n (rst_n), .en (en),
    .i0 (d8[0]), .i1 (d8[1]), .i2 (d8[2]), .i3 (d8[3]),
    .i4 (d8[4]), .i5 (d8[5]), .i6 (d8[6]), .i7 (d8[7]),
    .s (s), .y (y8), .y_comb (yc8), .s_q (sq8), .valid (v8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst_n   = 1'b0;
    en      = 1'b1;
    s       = 3'd0;
    for (int k = 0; k < 8; k++) begin
      a1[k] = 1'b0;
      d8[k] = 8'h00;
    end

    // Reset held with random inputs and en=1; y_comb still follows s.
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      s = 3'($urandom_range(0, 7));
      for (int k = 0; k < 8; k++) begin
        a1[k] = 1'($urandom);
        d8[k] = 8'($urandom);
      end
      #1;
      check("rst_ycomb8", 64'(yc8), 64'(d8[s]));
      check("rst_ycomb1", 64'(yc1), 64'(a1[s]));
      after_edge();
      check("rst_y8",     64'(y8),  64'h0);
      check("rst_sq8",    64'(sq8), 64'h0);
      check("rst_valid8", 64'(v8),  64'h0);
      check("rst_y1",     64'(y1),  64'h0);
      check("rst_valid1", 64'(v1),  64'h0);
    end

    // Select sweep (WIDTH=1 alternating 0/1) and one-hot walk (WIDTH=8).
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      a1[k] = 1'(k % 2);
      d8[k] = 8'h01 << k;
    end
    rst_n = 1'b1;
    en    = 1'b1;
    for (int k = 0; k < 8; k++) begin
      s = 3'(k);
      #1;
      check("sweep_ycomb1", 64'(yc1), 64'(k % 2));
      check("walk_ycomb8",  64'(yc8), 64'(8'h01 << k));
      after_edge();
      check("sweep_y1",     64'(y1),  64'(k % 2));
      check("sweep_sq1",    64'(sq1), 64'(k));
      check("sweep_valid1", 64'(v1),  64'h1);
      check("walk_y8",      64'(y8),  64'(8'h01 << k));
      check("walk_sq8",     64'(sq8), 64'(k));
      @(negedge clk);
    end

    // Enable hold: capture s=5, then disable and move s to 2.
    s = 3'd5;
    after_edge();
    check("hold_cap_y1",  64'(y1),  64'h1);
    check("hold_cap_sq1", 64'(sq1), 64'h5);
    @(negedge clk);
    en = 1'b0;
    s  = 3'd2;
    #1;
    check("hold_ycomb1", 64'(yc1), 64'h0);
    after_edge();
    check("hold_y1",     64'(y1),  64'h1);
    check("hold_sq1",    64'(sq1), 64'h5);
    check("hold_valid1", 64'(v1),  64'h1);
    check("hold_y8",     64'(y8),  64'h20);
    after_edge();
    check("hold2_y1",    64'(y1),  64'h1);
    @(negedge clk);
    en = 1'b1;
    after_edge();
    check("reen_y1",  64'(y1),  64'h0);
    check("reen_sq1", 64'(sq1), 64'h2);
    check("reen_y8",  64'(y8),  64'h04);

    // Asynchronous reset between edges.
    @(negedge clk);
    s = 3'd3;
    after_edge();
    check("pre_rst_y8", 64'(y8), 64'h08);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_y8",     64'(y8),  64'h0);
    check("arst_sq8",    64'(sq8), 64'h0);
    check("arst_valid8", 64'(v8),  64'h0);
    check("arst_y1",     64'(y1),  64'h0);
    check("arst_valid1", 64'(v1),  64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    s     = 3'd6;
    #1;
    check("rel_valid8", 64'(v8), 64'h0);
    after_edge();
    check("rel_y8",     64'(y8),  64'h40);
    check("rel_sq8",    64'(sq8), 64'h6);
    check("rel_valid8b",64'(v8),  64'h1);

    // Data changes with s fixed at 3.
    @(negedge clk);
    s     = 3'd3;
    a1[3] = 1'b0;
    d8[3] = 8'hA5;
    #1;
    check("dchg_ycomb1_a", 64'(yc1), 64'h0);
    check("dchg_ycomb8_a", 64'(yc8), 64'hA5);
    after_edge();
    check("dchg_y1_a", 64'(y1), 64'h0);
    check("dchg_y8_a", 64'(y8), 64'hA5);
    @(negedge clk);
    a1[3] = 1'b1;
    d8[3] = 8'h5A;
    #1;
    check("dchg_ycomb1_b", 64'(yc1), 64'h1);
    check("dchg_y1_lag",   64'(y1),  64'h0);
    check("dchg_y8_lag",   64'(y8),  64'hA5);
    after_edge();
    check("dchg_y1_b", 64'(y1), 64'h1);
    check("dchg_y8_b", 64'(y8), 64'h5A);
    @(negedge clk);
    a1[3] = 1'b0;
    #1;
    check("dchg_ycomb1_c", 64'(yc1), 64'h0);
    after_edge();
    check("dchg_y1_c", 64'(y1), 64'h0);

    // Simultaneous change of s and data: new select with new data.
    @(negedge clk);
    s     = 3'd7;
    d8[7] = 8'hC3;
    d8[3] = 8'h11;
    after_edge();
    check("simul_y8",  64'(y8),  64'hC3);
    check("simul_sq8", 64'(sq8), 64'h7);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/mux8_reg.md
Name: mux8_reg

Overview:
- Registered 8-to-1 multiplexer. One of eight equal-width data inputs is selected by a 3-bit select, and the result is captured into an output register.
- Used as a generic selection stage in datapaths that need a clean, glitch-free registered output.
- A combinational view of the selected input is also exported for same-cycle consumers.

Parameters:
- WIDTH, 1, bit width of each data input and of both outputs (legal range 1..64).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  capture enable for the output register.
- i0  input  WIDTH  data input, selected when s = 3'b000.
- i1  input  WIDTH  data input, selected when s = 3'b001.
- i2  input  WIDTH  data input, selected when s = 3'b010.
- i3  input  WIDTH  data input, selected when s = 3'b011.
- i4  input  WIDTH  data input, selected when s = 3'b100.
- i5  input  WIDTH  data input, selected when s = 3'b101.
- i6  input  WIDTH  data input, selected when s = 3'b110.
- i7  input  WIDTH  data input, selected when s = 3'b111.
- s  input  3  select code.
- y  output  WIDTH  registered selected data.
- y_comb  output  WIDTH  combinational selected data.
- s_q  output  3  select code that produced the current y.
- valid  output  1  high once y holds a captured value since reset.

Behaviour:
- Single clock domain. Reset is asynchronous assert, active-low, with release synchronised to clk in the integrating design.
- Reset values while rst_n = 0: y = 0, s_q = 0, valid = 0. These apply immediately, independent of clk.
- y_comb = input indexed by s, purely combinational, zero latency. It is unaffected by reset and en.
- All 8 select codes are decoded; there is no illegal code and no default/X path.
- X or Z on s must not be masked by a default branch in simulation: y_comb propagates X.
- On a rising clk edge with rst_n = 1 and en = 1: y <= y_comb, s_q <= s, valid <= 1.
  - Latency from s or data change to y is 1 cycle.
- On a rising clk edge with en = 0: y, s_q and valid hold their values.
- valid, once set, stays 1 until the next reset.
- A reset asserted mid-operation clears y, s_q and valid in the same instant. The first edge with en = 1 after release captures new data.
- Data inputs changing while s is constant: y_comb follows immediately, and y follows on the next enabled edge.
- Simultaneous change of s and the data inputs before an edge: the register captures the new s with the new data. No mixing of old and new values.
- No arithmetic. Width is preserved exactly: y and y_comb are WIDTH bits, with no extension or truncation.

Decomposition:
- Shared package: a select-code constant per input (SEL_I0..SEL_I7 = 0..7) and the select type as a 3-bit logic typedef.
- One natural sub-module: mux8_comb, the pure combinational 8:1 selector parameterised by WIDTH. It drives y_comb.
- The top level adds the enable register, s_q and valid.

Test Plan:
- Reset: hold rst_n = 0 with random inputs and toggling clk -> y = 0, s_q = 0, valid = 0; y_comb tracks s.
- Select sweep: WIDTH = 1, i0..i7 = 0,1,0,1,0,1,0,1, en = 1, s stepped 000..111 one per cycle -> y_comb = s[0] immediately; one cycle later y = s[0] and s_q = s; valid = 1 after the first edge.
- One-hot walk: WIDTH = 8, i_k = 8'h01 << k, s = k -> y = 8'h01 << k one cycle later, for k = 0..7.
- Enable hold: capture s = 3'b101 with i5 = 1, then set en = 0 and change s to 3'b010 (i2 = 0) -> y stays 1 and s_q stays 101 while y_comb = 0. Re-enable -> y = 0 on the next edge.
- Async reset mid-stream: s sweeping with en = 1, pull rst_n low between clock edges -> y and valid drop to 0 without a clock edge. After release, the first enabled edge captures the current selection.
- Data change with fixed s: s = 3'b011, i3 toggled 0 -> 1 -> 0 on successive cycles -> y_comb follows instantly and y follows with 1-cycle lag.
